// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, bus widths and response encoding.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // pslverr encoding, shared with the AXI4-Lite-to-APB bridge
  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_byte_reg.sv
// One 32-bit register: byte-strobed APB write merged with a full-word hardware write.
module apb_byte_reg
  import apb_pkg::*;
#(
  parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  apb_we_i,
  input  logic [APB_STRB_W-1:0] apb_strb_i,
  input  logic [APB_DATA_W-1:0] apb_wdata_i,
  input  logic                  hw_we_i,
  input  logic [APB_DATA_W-1:0] hw_wdata_i,
  output logic [APB_DATA_W-1:0] q_o
);

  logic [APB_DATA_W-1:0] data_d;
  logic [APB_DATA_W-1:0] data_q;

  // APB-strobed bytes win a same-cycle collision; the rest take the hardware word
  always_comb begin
    data_d = data_q;
    for (int unsigned b = 0; b < APB_STRB_W; b++) begin
      if (apb_we_i && apb_strb_i[b]) begin
        data_d[8*b +: 8] = apb_wdata_i[8*b +: 8];
      end else if (hw_we_i) begin
        data_d[8*b +: 8] = hw_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= RESET_VAL;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3/APB4 register-file completer with wait states, decode errors and a hardware update port.
// Define APB_REGFILE_PROT_CHECK_EN to reject non-secure accesses to the upper half of the registers.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                     s_apb_clk,
  input  logic                     s_apb_areset,
  input  logic [APB_ADDR_W-1:0]    s_apb_paddr,
  input  logic                     s_apb_psel,
  input  logic                     s_apb_penable,
  input  logic                     s_apb_pwrite,
  input  logic [APB_DATA_W-1:0]    s_apb_pwdata,
  input  logic [APB_STRB_W-1:0]    s_apb_pstrb,
  input  logic [2:0]               s_apb_pprot,
  output logic [APB_DATA_W-1:0]    s_apb_prdata,
  output logic                     s_apb_pready,
  output logic                     s_apb_pslverr,
  input  logic                     hw_wr_en,
  input  logic [5:0]               hw_wr_idx,
  input  logic [APB_DATA_W-1:0]    hw_wr_data,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  apb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic [5:0]            idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;

  logic [5:0]  setup_idx;
  logic        setup_err;
  logic        range_err;
  logic        prot_err;
  logic [32:0] addr_ext;
  logic [32:0] addr_lo;
  logic [32:0] addr_hi;

  // Bounds compared in 33 bits so BASE_ADDR + 4*NUM_REGS cannot wrap
  assign addr_ext  = {1'b0, s_apb_paddr};
  assign addr_lo   = {1'b0, BASE_ADDR};
  assign addr_hi   = addr_lo + 33'(4 * NUM_REGS);
  assign range_err = (s_apb_paddr[1:0] != 2'b00) || (addr_ext < addr_lo) || (addr_ext >= addr_hi);
  assign setup_idx = 6'((s_apb_paddr - BASE_ADDR) >> 2);

`ifdef APB_REGFILE_PROT_CHECK_EN
  assign prot_err = s_apb_pprot[1] && (32'(setup_idx) >= 32'(NUM_REGS / 2));
`else
  logic unused_pprot;
  assign unused_pprot = ^s_apb_pprot;
  assign prot_err     = 1'b0;
`endif

  assign setup_err = range_err || prot_err;

  always_ff @(posedge s_apb_clk or posedge s_apb_areset) begin
    if (s_apb_areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= APB_RESP_OKAY;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_STATES);
            idx_q   <= setup_idx;
            write_q <= s_apb_pwrite;
            err_q   <= setup_err ? APB_RESP_SLVERR : APB_RESP_OKAY;
            wdata_q <= s_apb_pwdata;
            strb_q  <= s_apb_pstrb;
          end
        end
        ACCESS: begin
          if (!s_apb_psel)            state_q <= IDLE;
          else if (cnt_q != '0)       cnt_q   <= cnt_q - 4'd1;
          else if (s_apb_penable)     state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic                  wr_commit;
  logic [APB_DATA_W-1:0] regs [NUM_REGS];
  logic [APB_DATA_W-1:0] rd_word;

  assign s_apb_pready  = (state_q == ACCESS) && (cnt_q == '0) && s_apb_psel && s_apb_penable;
  assign s_apb_pslverr = s_apb_pready && err_q;
  assign wr_commit     = s_apb_pready && write_q && !err_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    apb_byte_reg #(
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk_i       (s_apb_clk),
      .rst_i       (s_apb_areset),
      .apb_we_i    (wr_commit && (idx_q == 6'(i))),
      .apb_strb_i  (strb_q),
      .apb_wdata_i (wdata_q),
      .hw_we_i     (hw_wr_en && (hw_wr_idx == 6'(i))),
      .hw_wdata_i  (hw_wr_data),
      .q_o         (regs[i])
    );
    assign reg_q[32*i +: 32] = regs[i];
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_q == 6'(i)) rd_word = regs[i];
    end
  end

  assign s_apb_prdata = (s_apb_pready && !write_q && !err_q) ? rd_word : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: the driver queues expected completions, a monitor checks them.
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned NR   = 8;
  localparam int unsigned WS   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   paddr;
  logic          psel, penable, pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic          hw_en;
  logic [5:0]    hw_idx;
  logic [31:0]   hw_data;
  logic [NR*32-1:0] regq;

  apb_regfile_slave #(
    .BASE_ADDR   (BASE),
    .NUM_REGS    (NR),
    .WAIT_STATES (WS),
    .RESET_VAL   (32'h0000_0000)
  ) dut (
    .s_apb_clk     (clk),
    .s_apb_areset  (rst),
    .s_apb_paddr   (paddr),
    .s_apb_psel    (psel),
    .s_apb_penable (penable),
    .s_apb_pwrite  (pwrite),
    .s_apb_pwdata  (pwdata),
    .s_apb_pstrb   (pstrb),
    .s_apb_pprot   (pprot),
    .s_apb_prdata  (prdata),
    .s_apb_pready  (pready),
    .s_apb_pslverr (pslverr),
    .hw_wr_en      (hw_en),
    .hw_wr_idx     (hw_idx),
    .hw_wr_data    (hw_data),
    .reg_q         (regq)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] exp_regs [NR];
  int unsigned waits = 0;

  task automatic check(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [NR*32-1:0] exp_vec();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = exp_regs[i];
    return v;
  endfunction

  // Monitor: every completion pops one expectation; wait-state count and pslverr gating checked too
  always @(negedge clk) begin
    if (psel && penable) begin
      if (pready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("prdata", prdata, e[32:1]);
          check("pslverr", pslverr, e[0]);
          check("wait_states", waits, WS);
        end
        waits = 0;
      end else begin
        check("pslverr_low_when_not_ready", pslverr, 0);
        waits++;
      end
    end else begin
      waits = 0;
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic hw_col, input logic [5:0] hidx, input logic [31:0] hdata);
    int unsigned n;
    exp_q.push_back({exp_rd, exp_err});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n > 50) begin
        check("pready_timeout", 1, 0);
        break;
      end
    end
    if (hw_col) begin
      hw_en = 1'b1; hw_idx = hidx; hw_data = hdata;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; hw_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input logic err);
    apb_xfer(1'b1, addr, data, strb, 3'b000, 32'h0, err, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] exp, input logic err);
    apb_xfer(1'b0, addr, 32'h0, 4'h0, prot, exp, err, 1'b0, 6'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    hw_en = 0; hw_idx = 0; hw_data = 0;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_regs", regq, exp_vec());
    check("reset_pready", pready, 0);
    check("reset_pslverr", pslverr, 0);
    check("reset_prdata", prdata, 0);

    wr(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
    exp_regs[1] = 32'hDEAD_BEEF;
    check("write_full_reg1", regq, exp_vec());
    rd(BASE + 32'h4, 3'b000, 32'hDEAD_BEEF, 1'b0);

    wr(BASE + 32'h8, 32'h1122_3344, 4'hF, 1'b0);
    wr(BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, 1'b0);
    exp_regs[2] = 32'h11BB_33DD;
    check("partial_strobe", regq, exp_vec());
    rd(BASE + 32'h8, 3'b000, 32'h11BB_33DD, 1'b0);

    rd(BASE + 32'h20, 3'b000, 32'h0, 1'b1);
    wr(BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(BASE - 32'h4, 3'b000, 32'h0, 1'b1);
    wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("errors_no_write", regq, exp_vec());
    rd(BASE + 32'h1C, 3'b000, 32'h0, 1'b0);

    hw_en = 1; hw_idx = 6'd5; hw_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hw_idx = 6'd9; hw_data = 32'h5555_5555;
    @(posedge clk); #1;
    hw_en = 0;
    exp_regs[5] = 32'hCAFE_F00D;
    check("hw_write_and_oob_ignored", regq, exp_vec());

    apb_xfer(1'b1, BASE + 32'h18, 32'hFFFF_0000, 4'b1100, 3'b000, 32'h0, 1'b0, 1'b1, 6'd6, 32'h1234_5678);
    exp_regs[6] = 32'hFFFF_5678;
    check("collision_merge", regq, exp_vec());

    // abort: psel dropped during wait states
    psel = 1; penable = 0; pwrite = 1; paddr = BASE + 32'hC; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0;
    @(posedge clk); #1;
    check("abort_no_write", regq, exp_vec());
    rd(BASE + 32'hC, 3'b000, 32'h0, 1'b0);

    // penable without setup phase is ignored
    psel = 1; penable = 1; pwrite = 1; paddr = BASE; pwdata = 32'h1; pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1 psel = 0; penable = 0;
    @(posedge clk); #1;
    check("penable_in_idle_ignored", regq, exp_vec());

`ifdef APB_REGFILE_PROT_CHECK_EN
    rd(BASE + 32'h1C, 3'b010, 32'h0, 1'b1);
    apb_xfer(1'b1, BASE + 32'h1C, 32'h7777_7777, 4'hF, 3'b010, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
    check("prot_no_write", regq, exp_vec());
`endif

    // reset mid-access
    psel = 1; penable = 0; pwrite = 1; paddr = BASE; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    rst = 1;
    #2 rst = 0; psel = 0; penable = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    check("reset_mid_access_regs", regq, exp_vec());
    check("reset_mid_access_pready", pready, 0);
    rd(BASE + 32'h4, 3'b000, 32'h0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
